elevator_button_conditioner: RTL and testbench

Input-conditioning stage directly upstream of `ElevatorController` in the 2-car, 7-floor elevator design. It takes the raw, asynchronous, bouncing hall and car push-button lines, synchronises and debounces every bit independently, and emits single-cycle rising-edge pulses. These pulses drive `newRealFloorButton`, `newInternalButton1` and `newInternalButton2` one-for-one, with no bit remapping.

---
 rtl/elevator_button_conditioner_pkg.sv | 19 +
 rtl/elevator_button_conditioner_if.sv | 29 ++
 rtl/elevator_button_conditioner_debounce.sv | 66 ++++++
 rtl/elevator_button_conditioner.sv | 83 ++++++++
 tb/tb_elevator_button_conditioner.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/elevator_button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared constants for the 2-car, 7-floor elevator design, and a small helper
// for sizing counters.
// -----------------------------------------------------------------------------
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 7;
  localparam int unsigned HALL_BTN_W = 12;
  localparam int unsigned CAR_BTN_W  = 9;
  localparam int unsigned NUM_CARS   = 2;

  // Bits needed to hold 0..n-1. Never returns less than 1, so a
  // divide-by-1 prescaler still gets a legal one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_button_conditioner_if.sv
// -----------------------------------------------------------------------------
// elevator_button_conditioner_if
// Groups the raw push-button lines and the conditioned press pulses that
// travel between the button panels, the conditioner and the controller.
//   master : drives raw buttons, observes the press pulses
//   slave  : the conditioner; reads raw buttons, drives the press pulses
// Car panel buttons are numbered [9:1] to match the controller's naming.
// -----------------------------------------------------------------------------
interface elevator_button_conditioner_if;
  import elevator_pkg::*;

  logic [HALL_BTN_W-1:0] rawRealFloorButton;
  logic [CAR_BTN_W:1]    rawInternalButton1;
  logic [CAR_BTN_W:1]    rawInternalButton2;
  logic [HALL_BTN_W-1:0] newRealFloorButton;
  logic [CAR_BTN_W:1]    newInternalButton1;
  logic [CAR_BTN_W:1]    newInternalButton2;

  modport master (
    output rawRealFloorButton, rawInternalButton1, rawInternalButton2,
    input  newRealFloorButton, newInternalButton1, newInternalButton2
  );

  modport slave (
    input  rawRealFloorButton, rawInternalButton1, rawInternalButton2,
    output newRealFloorButton, newInternalButton1, newInternalButton2
  );

endinterface

// File: rtl/elevator_button_conditioner_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// One button channel: 2-flop synchroniser, tick-based debounce counter,
// accepted level and a registered one-cycle rising-edge pulse.
//   clk   : system clock
//   reset : asynchronous, active-low
//   tick  : debounce sample strobe from the shared prescaler
//   raw   : raw asynchronous button line, active-high
//   pulse : one-cycle pulse when the accepted level goes 0->1
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int unsigned DEBOUNCE_TICKS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             p_q, p_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (tick) begin
      // Any agreeing sample throws away the partial count, so bounce
      // shorter than DEBOUNCE_TICKS ticks never moves the accepted level.
      if (s2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = s2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Press only; releases are silent.
    p_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      p_q      <= 1'b0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  assign pulse = p_q;

endmodule

// File: rtl/elevator_button_conditioner.sv
// -----------------------------------------------------------------------------
// elevator_button_conditioner
// Synchronises and debounces all 30 hall/car push-buttons and emits one-cycle
// press pulses that feed the elevator controller bit-for-bit.
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous, active-low
//   btn   : button bus (slave side) - raw buttons in, press pulses out
//   tick  : debounce sample strobe, one cycle in every TICK_DIV
// -----------------------------------------------------------------------------
module elevator_button_conditioner
  import elevator_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  elevator_button_conditioner_if.slave  btn,
  output logic                          tick
);

  localparam int unsigned PCNT_W = cnt_width(TICK_DIV);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              tick_q, tick_d;

  // tick is registered as (pcnt == TICK_DIV-1) of the next state so it is
  // held low during reset even with TICK_DIV=1 and has no combinational path.
  always_comb begin
    pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PCNT_W'(1);
    tick_d = (pcnt_d == PCNT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  logic [HALL_BTN_W-1:0] hall_pulse;
  logic [CAR_BTN_W:1]    car1_pulse;
  logic [CAR_BTN_W:1]    car2_pulse;

  generate
    for (genvar gi = 0; gi < HALL_BTN_W; gi++) begin : g_hall
      button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_q),
        .raw   (btn.rawRealFloorButton[gi]),
        .pulse (hall_pulse[gi])
      );
    end
    for (genvar gi = 1; gi <= CAR_BTN_W; gi++) begin : g_car
      button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db1 (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_q),
        .raw   (btn.rawInternalButton1[gi]),
        .pulse (car1_pulse[gi])
      );
      button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db2 (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_q),
        .raw   (btn.rawInternalButton2[gi]),
        .pulse (car2_pulse[gi])
      );
    end
  endgenerate

  assign btn.newRealFloorButton = hall_pulse;
  assign btn.newInternalButton1 = car1_pulse;
  assign btn.newInternalButton2 = car2_pulse;

endmodule

// File: tb/tb_elevator_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_elevator_button_conditioner
// dut1: TICK_DIV=1, DEBOUNCE_TICKS=4 ; dut2: TICK_DIV=5, DEBOUNCE_TICKS=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_elevator_button_conditioner;
  import elevator_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst2_n;
  logic tick1, tick2;

  elevator_button_conditioner_if bus1 ();
  elevator_button_conditioner_if bus2 ();

  elevator_button_conditioner #(.TICK_DIV(1), .DEBOUNCE_TICKS(4)) dut1 (
    .clk (clk), .reset (rst_n), .btn (bus1), .tick (tick1)
  );
  elevator_button_conditioner #(.TICK_DIV(5), .DEBOUNCE_TICKS(4)) dut2 (
    .clk (clk), .reset (rst2_n), .btn (bus2), .tick (tick2)
  );

  logic [29:0] o1;
  assign o1 = {bus1.newRealFloorButton, bus1.newInternalButton1, bus1.newInternalButton2};

  typedef struct {
    logic [11:0] h;
    logic [9:1]  c1;
    logic [9:1]  c2;
    logic [11:0] eh;
    logic [9:1]  ec1;
    logic [9:1]  ec2;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic [11:0] h, input logic [9:1] c1, input logic [9:1] c2,
                     input logic [11:0] eh, input logic [9:1] ec1, input logic [9:1] ec2,
                     input int n);
    vec_t v;
    v.h = h; v.c1 = c1; v.c2 = c2; v.eh = eh; v.ec1 = ec1; v.ec2 = ec2;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  localparam logic [9:1] C1 = 9'b00_000_1010;
  localparam logic [9:1] C2 = 9'b00_000_1001;

  initial begin
    // Clean press of hall bit 0, release, then simultaneous presses incl. hall MSB.
    add(12'h001, '0, '0, 12'h000, '0, '0, 5);
    add(12'h001, '0, '0, 12'h001, '0, '0, 1);
    add(12'h001, '0, '0, 12'h000, '0, '0, 1);
    add(12'h000, '0, '0, 12'h000, '0, '0, 8);
    add(12'h800, C1, C2, 12'h000, '0, '0, 5);
    add(12'h800, C1, C2, 12'h800, C1, C2, 1);
    add(12'h800, C1, C2, 12'h000, '0, '0, 2);
    add(12'h000, '0, '0, 12'h000, '0, '0, 10);

    bus1.rawRealFloorButton = '0; bus1.rawInternalButton1 = '0; bus1.rawInternalButton2 = '0;
    bus2.rawRealFloorButton = '0; bus2.rawInternalButton1 = '0; bus2.rawInternalButton2 = '0;
    rst_n = 1'b0; rst2_n = 1'b0;
    step(); step(); step();
    check("reset_outputs", {2'b00, o1}, 32'h0);
    check("reset_tick_div1", tick1, 1'b0);
    rst_n = 1'b1; rst2_n = 1'b1;

    // ---------------- dut2: prescaler ----------------
    for (int j = 1; j <= 14; j++) begin
      step();
      if (j == 1) check("tick_div1_running", tick1, 1'b1);
      check("tick_period5", tick2, (j % 5) == 4);
    end
    for (int j = 15; j <= 18; j++) step();
    // Raw edge before edge 19 puts the first counted tick 6 edges later,
    // so a 19-cycle press only sees 3 ticks.
    bus2.rawRealFloorButton = 12'h001;
    pulses = 0;
    for (int k = 0; k < 19; k++) begin
      step();
      if (bus2.newRealFloorButton != '0) pulses++;
    end
    bus2.rawRealFloorButton = 12'h000;
    for (int k = 0; k < 23; k++) begin
      step();
      if (bus2.newRealFloorButton != '0) pulses++;
    end
    check("short_press_no_pulse", pulses, 0);
    step(); step(); step();
    // Same phase: ticks counted at E6, E11, E16, E21 -> pulse after E21.
    bus2.rawRealFloorButton = 12'h001;
    for (int k = 0; k < 30; k++) begin
      step();
      check("prescaled_press", bus2.newRealFloorButton, (k == 21) ? 12'h001 : 12'h000);
    end
    bus2.rawRealFloorButton = 12'h000;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus2.newRealFloorButton != '0) pulses++;
    end
    check("prescaled_release", pulses, 0);

    // ---------------- dut1: vector table ----------------
    foreach (tbl[i]) begin
      bus1.rawRealFloorButton = tbl[i].h;
      bus1.rawInternalButton1 = tbl[i].c1;
      bus1.rawInternalButton2 = tbl[i].c2;
      step();
      check($sformatf("vec%0d", i), {2'b00, o1}, {2'b00, tbl[i].eh, tbl[i].ec1, tbl[i].ec2});
    end

    // ---------------- bounce on hall bit 3 ----------------
    for (int k = 0; k <= 20; k++) begin
      bus1.rawRealFloorButton = (k < 2) ? 12'h008 : (k < 4) ? 12'h000 :
                                (k < 6) ? 12'h008 : (k < 8) ? 12'h000 : 12'h008;
      step();
      check("bounce", {2'b00, o1}, (k == 13) ? {2'b00, 12'h008, 18'h0} : 32'h0);
    end
    bus1.rawRealFloorButton = 12'h000;
    for (int k = 0; k < 12; k++) step();

    // ---------------- reset mid-debounce, hall bit 5 ----------------
    bus1.rawRealFloorButton = 12'h020;
    step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("reset_async_outputs", {2'b00, o1}, 32'h0);
    check("reset_async_tick", tick1, 1'b0);
    step(); step();
    check("reset_held_tick", tick1, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      check("press_through_reset", {2'b00, o1}, (k == 5) ? {2'b00, 12'h020, 18'h0} : 32'h0);
    end

    // ---------------- reset during a pulse ----------------
    bus1.rawRealFloorButton = 12'h000;
    for (int k = 0; k < 12; k++) step();
    bus1.rawRealFloorButton = 12'h020;
    for (int k = 0; k <= 5; k++) step();
    check("pulse_before_reset", bus1.newRealFloorButton, 12'h020);
    rst_n = 1'b0;
    #1;
    check("reset_drops_pulse", {2'b00, o1}, 32'h0);
    step();
    bus1.rawRealFloorButton = 12'h000;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o1 != '0) pulses++;
    end
    check("idle_after_reset", pulses, 0);

    // ---------------- re-press, hall bit 7 ----------------
    bus1.rawRealFloorButton = 12'h080;
    for (int k = 0; k <= 9; k++) begin
      step();
      check("first_press", {2'b00, o1}, (k == 5) ? {2'b00, 12'h080, 18'h0} : 32'h0);
    end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      bus1.rawRealFloorButton = (k < 3) ? 12'h000 : 12'h080;
      step();
      if (o1 != '0) pulses++;
    end
    check("short_release_no_repulse", pulses, 0);
    for (int k = 0; k <= 15; k++) begin
      bus1.rawRealFloorButton = (k < 6) ? 12'h000 : 12'h080;
      step();
      check("long_release_repulse", {2'b00, o1}, (k == 11) ? {2'b00, 12'h080, 18'h0} : 32'h0);
    end
    bus1.rawRealFloorButton = 12'h000;
    for (int k = 0; k < 10; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
